uop_fetch_decode: RTL and testbench

Two-stage micro-op front end of the microcode unit: a fetch stage (uop_fetch) walks the micro-op buffer and registers a two-instruction bundle with per-instruction branch tags, and a decode stage (uop_decode) registers that bundle and splits each instruction into fields. Both stages use the same valid/stall handshake and flush on `clear`. The block sits between the micro-op buffer (read combinationally via `uop_addr`/`uop`) and the downstream issue logic.

---
 rtl/uop_fetch_decode.sv | 180 ++++++++++++++++++
 tb/tb_uop_fetch_decode.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/uop_fetch_decode.sv
// Two-stage micro-op front end: fetch walks the micro-op buffer and tags branches,
// decode registers the bundle and splits each slot into its instruction fields.
module uop_fetch_decode #(
    parameter int UOP_BUF_SIZE = 16,
    parameter int INSTR_W      = 32,
    parameter int TAG_W        = 4,
    localparam int AW          = $clog2(UOP_BUF_SIZE)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     prev_valid,
    input  logic                     next_stalled,
    output logic [AW-1:0]            uop_addr,
    input  logic [2*INSTR_W-1:0]     uop,
    output logic                     fetch_valid,
    output logic                     fetch_stalled,
    output logic [INSTR_W+TAG_W-1:0] instruction_1,
    output logic [INSTR_W+TAG_W-1:0] instruction_2,
    output logic                     decode_valid,
    output logic                     decode_stalled,
    output logic [3:0]               d1_opcode,
    output logic [3:0]               d1_rd,
    output logic [3:0]               d1_rs1,
    output logic [3:0]               d1_rs2,
    output logic [15:0]              d1_imm,
    output logic [TAG_W-1:0]         d1_tag,
    output logic                     d1_is_branch,
    output logic [3:0]               d2_opcode,
    output logic [3:0]               d2_rd,
    output logic [3:0]               d2_rs1,
    output logic [3:0]               d2_rs2,
    output logic [15:0]              d2_imm,
    output logic [TAG_W-1:0]         d2_tag,
    output logic                     d2_is_branch
);

    localparam int FW = INSTR_W + TAG_W;

    // ------------------------------------------------------------------
    // Fetch stage state
    // ------------------------------------------------------------------
    logic [AW-1:0]    pc_reg;
    logic [AW-1:0]    pc_next;
    logic [TAG_W-1:0] tag_reg;
    logic [TAG_W-1:0] tag_next;
    logic             fetch_valid_reg;
    logic             fetch_load;

    logic [INSTR_W-1:0] slot_instr [2];
    logic               slot_branch [2];
    logic [TAG_W-1:0]   slot_tag [2];
    logic [FW-1:0]      instr_reg [2];

    // ------------------------------------------------------------------
    // Decode stage state
    // ------------------------------------------------------------------
    logic             decode_valid_reg;
    logic             decode_load;
    logic [3:0]       opcode_reg [2];
    logic [3:0]       rd_reg [2];
    logic [3:0]       rs1_reg [2];
    logic [3:0]       rs2_reg [2];
    logic [15:0]      imm_reg [2];
    logic [TAG_W-1:0] dtag_reg [2];
    logic             is_branch_reg [2];

    // Stall chain runs backwards combinationally; an invalid stage never stalls.
    assign decode_stalled = decode_valid_reg & next_stalled;
    assign fetch_stalled  = fetch_valid_reg & decode_stalled;

    assign fetch_load  = ~clear & ~fetch_stalled & prev_valid;
    assign decode_load = ~clear & ~decode_stalled;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot_split
            assign slot_instr[gi]  = uop[gi*INSTR_W +: INSTR_W];
            assign slot_branch[gi] = (slot_instr[gi][INSTR_W-1 -: 4] == 4'hF);
        end
    endgenerate

    // Slot 1 sees the tag already bumped by a branch in slot 0.
    assign slot_tag[0] = tag_reg;
    assign slot_tag[1] = tag_reg + TAG_W'(slot_branch[0]);
    assign tag_next    = slot_tag[1] + TAG_W'(slot_branch[1]);

    assign pc_next = (pc_reg == AW'(UOP_BUF_SIZE - 1)) ? '0 : pc_reg + AW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg          <= '0;
            tag_reg         <= '0;
            fetch_valid_reg <= 1'b0;
        end else if (clear) begin
            fetch_valid_reg <= 1'b0;
        end else if (!fetch_stalled) begin
            fetch_valid_reg <= prev_valid;
            if (prev_valid) begin
                pc_reg  <= pc_next;
                tag_reg <= tag_next;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fetch_slot
            always_ff @(posedge clk) begin
                if (reset) begin
                    instr_reg[gi] <= '0;
                end else if (fetch_load) begin
                    instr_reg[gi] <= {slot_tag[gi], slot_instr[gi]};
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            decode_valid_reg <= 1'b0;
        end else if (clear) begin
            decode_valid_reg <= 1'b0;
        end else if (!decode_stalled) begin
            decode_valid_reg <= fetch_valid_reg;
        end
    end

    // Field layout is fixed for 32-bit instructions; the tag rides above it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_decode_slot
            logic [INSTR_W-1:0] ins;
            assign ins = instr_reg[gi][INSTR_W-1:0];

            always_ff @(posedge clk) begin
                if (reset) begin
                    opcode_reg[gi]    <= '0;
                    rd_reg[gi]        <= '0;
                    rs1_reg[gi]       <= '0;
                    rs2_reg[gi]       <= '0;
                    imm_reg[gi]       <= '0;
                    dtag_reg[gi]      <= '0;
                    is_branch_reg[gi] <= 1'b0;
                end else if (decode_load) begin
                    opcode_reg[gi]    <= ins[31:28];
                    rd_reg[gi]        <= ins[27:24];
                    rs1_reg[gi]       <= ins[23:20];
                    rs2_reg[gi]       <= ins[19:16];
                    imm_reg[gi]       <= ins[15:0];
                    dtag_reg[gi]      <= instr_reg[gi][FW-1 -: TAG_W];
                    is_branch_reg[gi] <= (ins[31:28] == 4'hF);
                end
            end
        end
    endgenerate

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign uop_addr      = pc_reg;
    assign fetch_valid   = fetch_valid_reg;
    assign instruction_1 = instr_reg[0];
    assign instruction_2 = instr_reg[1];
    assign decode_valid  = decode_valid_reg;

    assign d1_opcode    = opcode_reg[0];
    assign d1_rd        = rd_reg[0];
    assign d1_rs1       = rs1_reg[0];
    assign d1_rs2       = rs2_reg[0];
    assign d1_imm       = imm_reg[0];
    assign d1_tag       = dtag_reg[0];
    assign d1_is_branch = is_branch_reg[0];

    assign d2_opcode    = opcode_reg[1];
    assign d2_rd        = rd_reg[1];
    assign d2_rs1       = rs1_reg[1];
    assign d2_rs2       = rs2_reg[1];
    assign d2_imm       = imm_reg[1];
    assign d2_tag       = dtag_reg[1];
    assign d2_is_branch = is_branch_reg[1];

endmodule

// File: tb/tb_uop_fetch_decode.sv
// Directed bench for uop_fetch_decode with an 8-entry buffer model.
module tb_uop_fetch_decode;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        prev_valid = 1'b0;
    logic        next_stalled = 1'b0;
    logic [2:0]  uop_addr;
    logic [63:0] uop;
    logic        fetch_valid, fetch_stalled, decode_valid, decode_stalled;
    logic [35:0] instruction_1, instruction_2;
    logic [3:0]  d1_opcode, d1_rd, d1_rs1, d1_rs2, d2_opcode, d2_rd, d2_rs1, d2_rs2;
    logic [15:0] d1_imm, d2_imm;
    logic [3:0]  d1_tag, d2_tag;
    logic        d1_is_branch, d2_is_branch;

    logic [63:0] mem [0:7];
    int checks = 0;
    int errors = 0;

    assign uop = mem[uop_addr];

    always #5 clk = ~clk;

    uop_fetch_decode #(.UOP_BUF_SIZE(8), .INSTR_W(32), .TAG_W(4)) dut (
        .clk(clk), .reset(reset), .clear(clear), .prev_valid(prev_valid),
        .next_stalled(next_stalled), .uop_addr(uop_addr), .uop(uop),
        .fetch_valid(fetch_valid), .fetch_stalled(fetch_stalled),
        .instruction_1(instruction_1), .instruction_2(instruction_2),
        .decode_valid(decode_valid), .decode_stalled(decode_stalled),
        .d1_opcode(d1_opcode), .d1_rd(d1_rd), .d1_rs1(d1_rs1), .d1_rs2(d1_rs2),
        .d1_imm(d1_imm), .d1_tag(d1_tag), .d1_is_branch(d1_is_branch),
        .d2_opcode(d2_opcode), .d2_rd(d2_rd), .d2_rs1(d2_rs1), .d2_rs2(d2_rs2),
        .d2_imm(d2_imm), .d2_tag(d2_tag), .d2_is_branch(d2_is_branch)
    );

    task automatic step();
        @(posedge clk);
        #1;
        $display("t=%0t addr=%0d fv=%b fs=%b i1=%h i2=%h dv=%b ds=%b d1imm=%h d2imm=%h",
                 $time, uop_addr, fetch_valid, fetch_stalled, instruction_1, instruction_2,
                 decode_valid, decode_stalled, d1_imm, d2_imm);
    endtask

    task automatic fill_normal();
        for (int k = 0; k < 8; k++) mem[k] = {32'h1000 + 32'(k), 32'(k)};
    endtask

    task automatic do_reset();
        prev_valid   = 1'b0;
        next_stalled = 1'b0;
        clear        = 1'b0;
        reset        = 1'b1;
        step();
        reset        = 1'b0;
    endtask

    task automatic test_reset();
        fill_normal();
        do_reset();
        checks++; if (uop_addr !== 3'd0) begin errors++; $display("FAIL reset_addr got %h exp 0", uop_addr); end
        checks++; if (fetch_valid !== 1'b0 || decode_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got fv=%b dv=%b exp 0 0", fetch_valid, decode_valid); end
        checks++; if (instruction_1 !== 36'h0 || instruction_2 !== 36'h0) begin errors++; $display("FAIL reset_instr got %h %h exp 0 0", instruction_1, instruction_2); end
        checks++; if (d1_imm !== 16'h0 || d2_opcode !== 4'h0 || d1_is_branch !== 1'b0) begin errors++; $display("FAIL reset_decode got imm=%h op=%h br=%b exp 0", d1_imm, d2_opcode, d1_is_branch); end
    endtask

    task automatic test_free_run_wrap();
        logic [2:0] ea;
        fill_normal();
        do_reset();
        prev_valid = 1'b1;
        step();
        checks++; if (uop_addr !== 3'd1 || fetch_valid !== 1'b1) begin errors++; $display("FAIL run_e1_addr got addr=%h fv=%b exp 1 1", uop_addr, fetch_valid); end
        checks++; if (instruction_1 !== 36'h0 || instruction_2 !== 36'h0_0000_1000) begin errors++; $display("FAIL run_e1_instr got %h %h exp 0 1000", instruction_1, instruction_2); end
        checks++; if (decode_valid !== 1'b0) begin errors++; $display("FAIL run_e1_dv got %b exp 0", decode_valid); end
        step();
        checks++; if (decode_valid !== 1'b1 || d1_imm !== 16'h0 || d2_imm !== 16'h1000 || d2_tag !== 4'h0) begin errors++; $display("FAIL run_e2_decode got dv=%b imm=%h/%h tag=%h exp 1 0/1000 0", decode_valid, d1_imm, d2_imm, d2_tag); end
        checks++; if (instruction_1 !== 36'h1 || uop_addr !== 3'd2) begin errors++; $display("FAIL run_e2_fetch got i1=%h addr=%h exp 1 2", instruction_1, uop_addr); end
        for (int k = 3; k < 8; k++) begin
            step();
            ea = 3'(k);
            checks++; if (uop_addr !== ea || instruction_1[31:0] !== 32'(k - 1)) begin errors++; $display("FAIL run_seq got addr=%h i1=%h exp %h %h", uop_addr, instruction_1, ea, k - 1); end
        end
        step();
        checks++; if (uop_addr !== 3'd0 || instruction_1 !== 36'h7 || instruction_2 !== 36'h1007) begin errors++; $display("FAIL wrap_e got addr=%h i1=%h i2=%h exp 0 7 1007", uop_addr, instruction_1, instruction_2); end
        step();
        checks++; if (uop_addr !== 3'd1 || instruction_1 !== 36'h0 || d1_imm !== 16'h7) begin errors++; $display("FAIL wrap_once got addr=%h i1=%h d1imm=%h exp 1 0 7", uop_addr, instruction_1, d1_imm); end
    endtask

    task automatic test_branch_tags();
        fill_normal();
        mem[0] = {32'h1234_0000, 32'hF000_0000};
        mem[1] = {32'h0000_0011, 32'h0000_0010};
        do_reset();
        prev_valid = 1'b1;
        step();
        checks++; if (instruction_1 !== 36'h0_F000_0000 || instruction_2 !== 36'h1_1234_0000) begin errors++; $display("FAIL tag_b0 got %h %h exp 0F0000000 112340000", instruction_1, instruction_2); end
        step();
        checks++; if (instruction_1 !== 36'h1_0000_0010 || instruction_2 !== 36'h1_0000_0011) begin errors++; $display("FAIL tag_b1 got %h %h exp 100000010 100000011", instruction_1, instruction_2); end
        checks++; if (d1_is_branch !== 1'b1 || d1_opcode !== 4'hF || d1_tag !== 4'h0 || d2_is_branch !== 1'b0 || d2_tag !== 4'h1) begin errors++; $display("FAIL tag_dec0 got br=%b op=%h t=%h br2=%b t2=%h exp 1 F 0 0 1", d1_is_branch, d1_opcode, d1_tag, d2_is_branch, d2_tag); end
        checks++; if (d2_rd !== 4'h2 || d2_rs1 !== 4'h3 || d2_rs2 !== 4'h4 || d2_imm !== 16'h0) begin errors++; $display("FAIL tag_fields got rd=%h rs1=%h rs2=%h imm=%h exp 2 3 4 0", d2_rd, d2_rs1, d2_rs2, d2_imm); end
        for (int k = 0; k < 8; k++) mem[k] = {32'hF000_0001, 32'hF000_0000};
        do_reset();
        prev_valid = 1'b1;
        for (int k = 0; k < 8; k++) step();
        checks++; if (instruction_1[35:32] !== 4'hE || instruction_2[35:32] !== 4'hF) begin errors++; $display("FAIL tag_16th got %h %h exp E F", instruction_1[35:32], instruction_2[35:32]); end
        step();
        checks++; if (instruction_1[35:32] !== 4'h0 || instruction_2[35:32] !== 4'h1) begin errors++; $display("FAIL tag_wrap got %h %h exp 0 1", instruction_1[35:32], instruction_2[35:32]); end
    endtask

    task automatic test_stall();
        fill_normal();
        do_reset();
        prev_valid = 1'b1;
        step(); step(); step();
        next_stalled = 1'b1;
        #1;
        checks++; if (decode_stalled !== 1'b1 || fetch_stalled !== 1'b1) begin errors++; $display("FAIL stall_comb got ds=%b fs=%b exp 1 1", decode_stalled, fetch_stalled); end
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (uop_addr !== 3'd3 || instruction_1 !== 36'h2 || d1_imm !== 16'h1 || fetch_stalled !== 1'b1) begin errors++; $display("FAIL stall_hold got addr=%h i1=%h d1imm=%h fs=%b exp 3 2 1 1", uop_addr, instruction_1, d1_imm, fetch_stalled); end
        end
        next_stalled = 1'b0;
        step();
        checks++; if (uop_addr !== 3'd4 || instruction_1 !== 36'h3 || d1_imm !== 16'h2 || decode_valid !== 1'b1) begin errors++; $display("FAIL stall_rel1 got addr=%h i1=%h d1imm=%h dv=%b exp 4 3 2 1", uop_addr, instruction_1, d1_imm, decode_valid); end
        step();
        checks++; if (instruction_1 !== 36'h4 || d1_imm !== 16'h3) begin errors++; $display("FAIL stall_rel2 got i1=%h d1imm=%h exp 4 3", instruction_1, d1_imm); end
    endtask

    task automatic test_bubble();
        fill_normal();
        do_reset();
        prev_valid = 1'b1;
        step(); step();
        prev_valid = 1'b0;
        step();
        checks++; if (fetch_valid !== 1'b0 || uop_addr !== 3'd2 || decode_valid !== 1'b1 || d1_imm !== 16'h1) begin errors++; $display("FAIL bub1 got fv=%b addr=%h dv=%b d1imm=%h exp 0 2 1 1", fetch_valid, uop_addr, decode_valid, d1_imm); end
        step();
        checks++; if (fetch_valid !== 1'b0 || decode_valid !== 1'b0 || uop_addr !== 3'd2) begin errors++; $display("FAIL bub2 got fv=%b dv=%b addr=%h exp 0 0 2", fetch_valid, decode_valid, uop_addr); end
        prev_valid = 1'b1;
        step();
        checks++; if (fetch_valid !== 1'b1 || instruction_1 !== 36'h2 || uop_addr !== 3'd3 || decode_valid !== 1'b0) begin errors++; $display("FAIL bub3 got fv=%b i1=%h addr=%h dv=%b exp 1 2 3 0", fetch_valid, instruction_1, uop_addr, decode_valid); end
        step();
        checks++; if (decode_valid !== 1'b1 || d1_imm !== 16'h2) begin errors++; $display("FAIL bub4 got dv=%b d1imm=%h exp 1 2", decode_valid, d1_imm); end
    endtask

    task automatic test_clear_reset();
        fill_normal();
        mem[4] = {32'hF000_1004, 32'hF000_0004};
        do_reset();
        prev_valid = 1'b1;
        step(); step(); step();
        next_stalled = 1'b1;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        checks++; if (fetch_valid !== 1'b0 || decode_valid !== 1'b0 || uop_addr !== 3'd3 || fetch_stalled !== 1'b0) begin errors++; $display("FAIL clr got fv=%b dv=%b addr=%h fs=%b exp 0 0 3 0", fetch_valid, decode_valid, uop_addr, fetch_stalled); end
        next_stalled = 1'b0;
        step();
        checks++; if (fetch_valid !== 1'b1 || instruction_1 !== 36'h3 || uop_addr !== 3'd4 || decode_valid !== 1'b0) begin errors++; $display("FAIL clr_resume got fv=%b i1=%h addr=%h dv=%b exp 1 3 4 0", fetch_valid, instruction_1, uop_addr, decode_valid); end
        step();
        checks++; if (instruction_2 !== 36'h1_F000_1004) begin errors++; $display("FAIL clr_br got %h exp 1F0001004", instruction_2); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++; if (uop_addr !== 3'd0 || fetch_valid !== 1'b0 || instruction_2 !== 36'h0) begin errors++; $display("FAIL mid_reset got addr=%h fv=%b i2=%h exp 0 0 0", uop_addr, fetch_valid, instruction_2); end
        step();
        checks++; if (fetch_valid !== 1'b1 || instruction_1[35:32] !== 4'h0 || instruction_2 !== 36'h0_0000_1000) begin errors++; $display("FAIL reset_tag got fv=%b t=%h i2=%h exp 1 0 000001000", fetch_valid, instruction_1[35:32], instruction_2); end
    endtask

    initial begin
        test_reset();
        test_free_run_wrap();
        test_branch_tags();
        test_stall();
        test_bubble();
        test_clear_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
